// File: rtl/demux_scheduler.sv
// demux_scheduler: round-robin arbiter that drives the sel/enable controls of a
// 1-to-4 demux, holds each grant for at most HOLD cycles and inserts a single
// dead cycle between grants.
//
// Ports:
//   clk     in   system clock, all state changes on rising edge
//   reset   in   synchronous active-high reset
//   req     in   [3:0] request lines, req[i] asks for demux output i
//   sel     out  [1:0] demux select, index of current/last grant
//   enable  out  demux enable, high only while a grant is active
//   grant   out  [3:0] one-hot grant, grant[i] = enable && sel == i
//   busy    out  high whenever the scheduler is not idle
module demux_scheduler #(
  parameter int unsigned HOLD = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  output logic [1:0] sel,
  output logic       enable,
  output logic [3:0] grant,
  output logic       busy
);

  localparam int unsigned NREQ  = 4;
  localparam int unsigned IDX_W = 2;
  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   last;
  logic [CNT_W-1:0]   cnt;

  logic               arb_found_c;
  logic [IDX_W-1:0]   arb_win_c;

  // Round-robin search starting just after the most recent grant.
  always_comb begin
    logic [IDX_W-1:0] idx;
    arb_found_c = 1'b0;
    arb_win_c   = '0;
    idx         = '0;
    for (int k = 1; k <= int'(NREQ); k++) begin
      idx = last + IDX_W'(k);
      if (!arb_found_c && req[idx]) begin
        arb_found_c = 1'b1;
        arb_win_c   = idx;
      end
    end
  end

  // Scheduler state machine; every output is a register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      sel    <= '0;
      enable <= 1'b0;
      grant  <= '0;
      busy   <= 1'b0;
      last   <= 2'b11;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE, GAP: begin
          if (arb_found_c) begin
            state  <= GRANT;
            sel    <= arb_win_c;
            enable <= 1'b1;
            grant  <= 4'b0001 << arb_win_c;
            busy   <= 1'b1;
            last   <= arb_win_c;
            cnt    <= CNT_W'(HOLD - 1);
          end else begin
            state  <= IDLE;
            enable <= 1'b0;
            grant  <= '0;
            busy   <= 1'b0;
          end
        end
        GRANT: begin
          // Holder dropping its request wins over count expiry; both end in GAP.
          if (!req[sel] || cnt == '0) begin
            state  <= GAP;
            enable <= 1'b0;
            grant  <= '0;
            busy   <= 1'b1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state  <= IDLE;
          enable <= 1'b0;
          grant  <= '0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_demux_scheduler.sv
module tb_demux_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] req4 = '0;
  logic [3:0] req1 = '0;

  logic [1:0] sel4, sel1;
  logic       en4, en1, busy4, busy1;
  logic [3:0] grant4, grant1;

  int n_checks = 0;
  int n_fails  = 0;

  demux_scheduler #(.HOLD(4)) dut4 (
    .clk(clk), .reset(reset), .req(req4),
    .sel(sel4), .enable(en4), .grant(grant4), .busy(busy4)
  );

  demux_scheduler #(.HOLD(1)) dut1 (
    .clk(clk), .reset(reset), .req(req1),
    .sel(sel1), .enable(en1), .grant(grant1), .busy(busy1)
  );

  always #5 clk = ~clk;

  // Behavioural model: who holds the output, how many cycles it has used,
  // and where the round-robin pointer sits. Index 0 models HOLD=4, 1 models HOLD=1.
  int hold_of  [2] = '{4, 1};
  int m_holder [2] = '{-1, -1};
  int m_used   [2] = '{0, 0};
  int m_ptr    [2] = '{3, 3};
  int m_sel    [2] = '{0, 0};
  bit m_busy   [2] = '{0, 0};

  task automatic model_step();
    logic [3:0] r;
    int w;
    for (int d = 0; d < 2; d++) begin
      r = (d == 0) ? req4 : req1;
      if (reset) begin
        m_holder[d] = -1; m_used[d] = 0; m_ptr[d] = 3; m_sel[d] = 0; m_busy[d] = 0;
      end else if (m_holder[d] >= 0) begin
        if (!r[m_holder[d]] || m_used[d] == hold_of[d]) begin
          m_holder[d] = -1;
          m_busy[d]   = 1;
        end else begin
          m_used[d]++;
        end
      end else begin
        w = -1;
        for (int k = 1; k <= 4; k++)
          if (w < 0 && r[(m_ptr[d] + k) % 4]) w = (m_ptr[d] + k) % 4;
        if (w >= 0) begin
          m_holder[d] = w; m_used[d] = 1; m_ptr[d] = w; m_sel[d] = w; m_busy[d] = 1;
        end else begin
          m_busy[d] = 0;
        end
      end
    end
  endtask

  function automatic logic [7:0] exp_vec(int d);
    logic [7:0] v;
    v[7:6] = 2'(m_sel[d]);
    v[5]   = (m_holder[d] >= 0);
    v[4:1] = (m_holder[d] >= 0) ? (4'b0001 << m_holder[d]) : 4'b0000;
    v[0]   = m_busy[d];
    return v;
  endfunction

  // Advance one clock: model samples the same inputs the DUT sees, then settle.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; req4 = 4'b1111; req1 = 4'b1111;
    for (int t = 0; t < 2; t++) begin
      tick();
      if ({sel4, en4, grant4, busy4} !== 8'h00) begin
        n_fails++;
        $display("FAIL reset_hold4 t=%0d got=%h exp=00", t, {sel4, en4, grant4, busy4});
      end
      n_checks++;
      if ({sel1, en1, grant1, busy1} !== 8'h00) begin
        n_fails++;
        $display("FAIL reset_hold1 t=%0d got=%h exp=00", t, {sel1, en1, grant1, busy1});
      end
      n_checks++;
    end
    reset = 1'b0;
    tick();
    if (grant4 !== 4'b0001 || en4 !== 1'b1 || busy4 !== 1'b1) begin
      n_fails++;
      $display("FAIL reset_first_grant got grant=%b en=%b busy=%b exp grant=0001 en=1 busy=1",
               grant4, en4, busy4);
    end
    n_checks++;
    if ({sel4, en4, grant4, busy4} !== exp_vec(0)) begin
      n_fails++;
      $display("FAIL reset_model got=%h exp=%h", {sel4, en4, grant4, busy4}, exp_vec(0));
    end
    n_checks++;
  endtask

  task automatic test_single();
    logic [3:0] eg;
    req4 = 4'b0000; req1 = 4'b0000;
    do_reset();
    req4 = 4'b0100;
    for (int t = 0; t < 10; t++) begin
      tick();
      eg = ((t % 5) < 4) ? 4'b0100 : 4'b0000;
      if (grant4 !== eg || sel4 !== 2'b10 || busy4 !== 1'b1) begin
        n_fails++;
        $display("FAIL single t=%0d got grant=%b sel=%b busy=%b exp grant=%b sel=10 busy=1",
                 t, grant4, sel4, busy4, eg);
      end
      n_checks++;
      if ({sel4, en4, grant4, busy4} !== exp_vec(0)) begin
        n_fails++;
        $display("FAIL single_model t=%0d got=%h exp=%h", t, {sel4, en4, grant4, busy4}, exp_vec(0));
      end
      n_checks++;
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] eg;
    logic [1:0] es;
    req4 = 4'b0000;
    do_reset();
    req4 = 4'b1111;
    for (int t = 0; t < 25; t++) begin
      tick();
      es = 2'((t / 5) % 4);
      eg = ((t % 5) < 4) ? (4'b0001 << es) : 4'b0000;
      if (grant4 !== eg || sel4 !== es || en4 !== (eg != 4'b0000)) begin
        n_fails++;
        $display("FAIL round_robin t=%0d got grant=%b sel=%b en=%b exp grant=%b sel=%b",
                 t, grant4, sel4, en4, eg, es);
      end
      n_checks++;
    end
  endtask

  task automatic test_early_release();
    req4 = 4'b0000;
    do_reset();
    req4 = 4'b1010;
    tick();
    tick();
    if (grant4 !== 4'b0010) begin
      n_fails++;
      $display("FAIL early_holder got=%b exp=0010", grant4);
    end
    n_checks++;
    req4 = 4'b1000;
    tick();
    if (en4 !== 1'b0 || grant4 !== 4'b0000 || busy4 !== 1'b1 || sel4 !== 2'b01) begin
      n_fails++;
      $display("FAIL early_gap got en=%b grant=%b busy=%b sel=%b exp en=0 grant=0000 busy=1 sel=01",
               en4, grant4, busy4, sel4);
    end
    n_checks++;
    tick();
    if (grant4 !== 4'b1000 || sel4 !== 2'b11) begin
      n_fails++;
      $display("FAIL early_next got grant=%b sel=%b exp grant=1000 sel=11", grant4, sel4);
    end
    n_checks++;
  endtask

  task automatic test_reset_mid();
    req4 = 4'b0000;
    do_reset();
    req4 = 4'b0100;
    for (int t = 0; t < 3; t++) tick();
    reset = 1'b1;
    tick();
    if ({sel4, en4, grant4, busy4} !== 8'h00) begin
      n_fails++;
      $display("FAIL midreset_values got=%h exp=00", {sel4, en4, grant4, busy4});
    end
    n_checks++;
    reset = 1'b0;
    tick();
    if (grant4 !== 4'b0100 || sel4 !== 2'b10) begin
      n_fails++;
      $display("FAIL midreset_regrant got grant=%b sel=%b exp grant=0100 sel=10", grant4, sel4);
    end
    n_checks++;
    // Second mid-grant reset: pointer must restart at 3, so 1001 picks requester 0.
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req4 = 4'b1001;
    tick();
    if (grant4 !== 4'b0001) begin
      n_fails++;
      $display("FAIL midreset_pointer got=%b exp=0001", grant4);
    end
    n_checks++;
  endtask

  task automatic test_hold1();
    logic [3:0] eg;
    req4 = 4'b0000; req1 = 4'b0000;
    do_reset();
    req1 = 4'b0011;
    for (int t = 0; t < 8; t++) begin
      tick();
      eg = (t % 2 == 0) ? (4'b0001 << ((t / 2) % 2)) : 4'b0000;
      if (grant1 !== eg || en1 !== (t % 2 == 0)) begin
        n_fails++;
        $display("FAIL hold1 t=%0d got grant=%b en=%b exp grant=%b", t, grant1, en1, eg);
      end
      n_checks++;
      if ({sel1, en1, grant1, busy1} !== exp_vec(1)) begin
        n_fails++;
        $display("FAIL hold1_model t=%0d got=%h exp=%h", t, {sel1, en1, grant1, busy1}, exp_vec(1));
      end
      n_checks++;
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 600; t++) begin
      reset = ($urandom_range(0, 59) == 0);
      // Bias toward holding requests so full-length grants occur often.
      if ($urandom_range(0, 3) == 0) req4 = 4'($urandom);
      if ($urandom_range(0, 3) == 0) req1 = 4'($urandom);
      tick();
      if ({sel4, en4, grant4, busy4} !== exp_vec(0)) begin
        n_fails++;
        $display("FAIL random_hold4 t=%0d got=%h exp=%h", t, {sel4, en4, grant4, busy4}, exp_vec(0));
      end
      n_checks++;
      if ({sel1, en1, grant1, busy1} !== exp_vec(1)) begin
        n_fails++;
        $display("FAIL random_hold1 t=%0d got=%h exp=%h", t, {sel1, en1, grant1, busy1}, exp_vec(1));
      end
      n_checks++;
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_early_release();
    test_reset_mid();
    test_hold1();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
